dig_in_cond: RTL and testbench
==============================

// Module: dig_in_cond
// PURPOSE
//  Input conditioner directly upstream of DigInPort: takes WIDTH raw asynchronous pins,
//  synchronises them, debounces each bit, and drives the stable, clean value into
//  DigInPort.iDIn. Also provides per-bit rise/fall pulses and sticky event flags for
//  later interrupt/status logic. Removes the metastability and glitch exposure on iDIn.
// PARAMETERS
//  WIDTH            8  number of input bits
//  SYNC_STAGES      2  flip-flop synchroniser depth; legal values are >= 2
//  DEBOUNCE_CYCLES  4  consecutive stable sync'd cycles needed to accept a change; legal values are >= 1
// PORTS
//  iCLK    in   1      single system clock
//  iRST    in   1      reset; synchronous, active-high
//  iDIn    in   WIDTH  raw asynchronous pins
//  iClr    in   WIDTH  per-bit clear for oEvt (synchronous, level)
//  oDOut   out  WIDTH  debounced stable value (to DigInPort.iDIn)
//  oRise   out  WIDTH  1-cycle pulse per bit on accepted 0->1
//  oFall   out  WIDTH  1-cycle pulse per bit on accepted 1->0
//  oEvt    out  WIDTH  sticky per-bit "changed" flag
// BEHAVIOUR
//  Reset: on an iCLK edge with iRST=1, the following all go to 0: sync chain, debounce counters,
//   oDOut, oRise, oFall, oEvt. iRST asserted during a debounce aborts the debounce and clears all state.
//  Sync: iDIn shifts through SYNC_STAGES flops; the last stage is sync[i]. No logic sits
//   between the stages.
//  Debounce, independently per bit i, with counter cnt[i] of width clog2(DEBOUNCE_CYCLES)
//   (minimum 1 bit):
//   - sync[i]==oDOut[i]: cnt[i]<=0 (a glitch cancels the pending change).
//   - sync[i]!=oDOut[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//   - sync[i]!=oDOut[i] and cnt[i]==DEBOUNCE_CYCLES-1: oDOut[i]<=sync[i], cnt[i]<=0.
//  Latency: a change held stable on iDIn updates oDOut on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th
//   edge after the first edge that samples the change. With the defaults this is 6 edges.
//   With DEBOUNCE_CYCLES=1 there is no filtering: latency is SYNC_STAGES+1.
//  Rejection: a pulse that is seen at sync[i] for fewer than DEBOUNCE_CYCLES cycles
//   never reaches oDOut.
//  Edges: oRise[i]/oFall[i] are registered. Each is high for exactly the 1 cycle in which the new
//   oDOut value first appears, and low in all other cycles. Both are never high together on one bit.
//  Sticky: oEvt[i]<=(oEvt[i] & ~iClr[i]) | oRise_next[i] | oFall_next[i].
//   When iClr[i] and a new edge occur in the same cycle, the set wins and no event is lost.
//  Bits are fully independent. Simultaneous changes on several bits are handled in parallel
//   with identical latency.
//  No bus interface exists here; DigInPort owns the bus.
// TESTING
//  1 Hold iRST=1 for 2 edges with iDIn=0xFF -> oDOut, oRise, oFall and oEvt are all 0x00. Release -> oDOut
//    reaches 0xFF 6 edges later.
//  2 From 0x00, step iDIn to 0xAB 2ns after an edge and hold it -> oDOut=0xAB on the 6th edge after,
//    oRise=0xAB for 1 cycle, oFall=0x00, oEvt=0xAB.
//  3 Step 0xAB->0xCD -> after 6 edges oDOut=0xCD, oRise=0x44, oFall=0x22 (1 cycle each), oEvt=0xEF.
//  4 Glitch bit0 high for 3 cycles (less than 4 stable cycles) -> oDOut, oRise and oEvt remain unchanged.
//    Then hold it for 4+ cycles -> bit0 is accepted.
//  5 Assert iClr=0xFF in the same cycle that oRise=0x01 would assert -> oEvt=0x01 afterwards.
//    Then iClr=0x01 alone -> oEvt=0x00.
//  6 Assert iRST 2 cycles into a pending change -> all outputs are 0 next cycle. After
//    release, the change completes with full latency counted from release.

Source files
------------

// File: rtl/dig_in_cond_if.sv
// Purpose: pin-side bundle of the digital input conditioner (raw pins, event clear, conditioned outputs).
// Ports:   master = pin/consumer side (drives iDIn, iClr; observes conditioned outputs);
//          slave  = conditioner side (samples iDIn, iClr; drives oDOut, oRise, oFall, oEvt).
interface dig_in_cond_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] iDIn;   // raw asynchronous pins
   logic [WIDTH-1:0] iClr;   // per-bit level clear for oEvt
   logic [WIDTH-1:0] oDOut;  // debounced stable value
   logic [WIDTH-1:0] oRise;  // 1-cycle pulse on accepted 0->1
   logic [WIDTH-1:0] oFall;  // 1-cycle pulse on accepted 1->0
   logic [WIDTH-1:0] oEvt;   // sticky per-bit changed flag

   modport master (
      output iDIn, iClr,
      input  oDOut, oRise, oFall, oEvt
   );

   modport slave (
      input  iDIn, iClr,
      output oDOut, oRise, oFall, oEvt
   );
endinterface

// File: rtl/dig_in_cond.sv
// Purpose: synchronise, debounce and edge-detect WIDTH raw pins; feeds DigInPort.iDIn.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first sampling edge to oDOut; no backpressure (free-running).
// Ports:   iCLK clock, iRST sync active-high reset, bus (slave): iDIn/iClr in, oDOut/oRise/oFall/oEvt out.
module dig_in_cond #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic          iCLK,
   input  logic          iRST,
   dig_in_cond_if.slave  bus
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]                  dout_q, dout_d;
   logic [WIDTH-1:0]                  rise_q, rise_d;
   logic [WIDTH-1:0]                  fall_q, fall_d;
   logic [WIDTH-1:0]                  evt_q, evt_d;
   logic [WIDTH-1:0]                  sync_last;

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_comb begin
      // Plain shift chain: nothing may sit between synchroniser stages.
      sync_d[0] = bus.iDIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end

      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_last[i] == dout_q[i]) begin
            // Any return to the accepted value cancels the pending change.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            dout_d[i] = sync_last[i];
            cnt_d[i]  = '0;
            rise_d[i] = sync_last[i];
            fall_d[i] = ~sync_last[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end

      // A new edge overrides a simultaneous clear so no event is lost.
      evt_d = (evt_q & ~bus.iClr) | rise_d | fall_d;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync_q <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
         evt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         evt_q  <= evt_d;
      end
   end

   assign bus.oDOut = dout_q;
   assign bus.oRise = rise_q;
   assign bus.oFall = fall_q;
   assign bus.oEvt  = evt_q;

endmodule

// File: tb/tb_dig_in_cond.sv
module tb_dig_in_cond;

   localparam int W = 8;
   localparam int S = 2;
   localparam int D = 4;

   logic clk;
   logic rst;

   dig_in_cond_if #(.WIDTH(W)) bus ();

   dig_in_cond #(
      .WIDTH(W),
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed table: apply inputs for n edges, then compare outputs.
   typedef struct {
      logic       rst;
      logic [W-1:0] din;
      logic [W-1:0] clr;
      int         n;
      logic [W-1:0] dout;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic [W-1:0] evt;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [W-1:0] din, input logic [W-1:0] clr, input int n,
                      input logic [W-1:0] dout, input logic [W-1:0] rise,
                      input logic [W-1:0] fall, input logic [W-1:0] evt);
      vec_t v;
      v.rst = r; v.din = din; v.clr = clr; v.n = n;
      v.dout = dout; v.rise = rise; v.fall = fall; v.evt = evt;
      vt.push_back(v);
   endtask

   // Reference model: a pin change is accepted once the last D values leaving
   // the synchroniser all disagree with the currently accepted value.
   logic [W-1:0] m_pipe [S];
   logic [W-1:0] m_win  [D];
   logic [W-1:0] m_out, m_rise, m_fall, m_evt;

   task automatic model_step(input logic r, input logic [W-1:0] din, input logic [W-1:0] clr);
      logic [W-1:0] seen, acc;
      if (r) begin
         for (int s = 0; s < S; s++) m_pipe[s] = '0;
         for (int j = 0; j < D; j++) m_win[j] = '0;
         m_out = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      end else begin
         seen = m_pipe[S-1];
         for (int j = D-1; j > 0; j--) m_win[j] = m_win[j-1];
         m_win[0] = seen;
         acc = '1;
         for (int j = 0; j < D; j++) acc &= (m_win[j] ^ m_out);
         m_rise = acc & seen;
         m_fall = acc & ~seen;
         m_evt  = (m_evt & ~clr) | m_rise | m_fall;
         m_out  = m_out ^ acc;
         for (int s = S-1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
         m_pipe[0] = din;
      end
   endtask

   initial begin
      logic [W-1:0] din_r, clr_r;
      logic         rst_r;

      rst = 1'b1;
      bus.iDIn = '0;
      bus.iClr = '0;

      //  rst   din    clr    n  dout   rise   fall   evt
      // reset then release with all pins high
      add(1'b1, 8'hFF, 8'h00, 2, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hFF, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hFF, 8'h00, 1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
      add(1'b0, 8'hFF, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'hFF);
      add(1'b0, 8'hFF, 8'hFF, 1, 8'hFF, 8'h00, 8'h00, 8'h00);
      // return to 0x00
      add(1'b0, 8'h00, 8'h00, 5, 8'hFF, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'hFF, 8'hFF);
      add(1'b0, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 8'h00);
      // 0x00 -> 0xAB
      add(1'b0, 8'hAB, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hAB, 8'h00, 1, 8'hAB, 8'hAB, 8'h00, 8'hAB);
      add(1'b0, 8'hAB, 8'h00, 1, 8'hAB, 8'h00, 8'h00, 8'hAB);
      // 0xAB -> 0xCD
      add(1'b0, 8'hCD, 8'h00, 5, 8'hAB, 8'h00, 8'h00, 8'hAB);
      add(1'b0, 8'hCD, 8'h00, 1, 8'hCD, 8'h44, 8'h22, 8'hEF);
      add(1'b0, 8'hCD, 8'h00, 1, 8'hCD, 8'h00, 8'h00, 8'hEF);
      // bit0 low, clear events
      add(1'b0, 8'hCC, 8'hFF, 5, 8'hCD, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hCC, 8'h00, 1, 8'hCC, 8'h00, 8'h01, 8'h01);
      add(1'b0, 8'hCC, 8'h01, 1, 8'hCC, 8'h00, 8'h00, 8'h00);
      // 3-cycle glitch on bit0 is rejected
      add(1'b0, 8'hCD, 8'h00, 3, 8'hCC, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hCC, 8'h00, 8, 8'hCC, 8'h00, 8'h00, 8'h00);
      // held bit0 is accepted
      add(1'b0, 8'hCD, 8'h00, 5, 8'hCC, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hCD, 8'h00, 1, 8'hCD, 8'h01, 8'h00, 8'h01);
      // clear colliding with a new rise: set wins
      add(1'b0, 8'hCC, 8'h00, 6, 8'hCC, 8'h00, 8'h01, 8'h01);
      add(1'b0, 8'hCC, 8'h01, 1, 8'hCC, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hCD, 8'h00, 5, 8'hCC, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hCD, 8'hFF, 1, 8'hCD, 8'h01, 8'h00, 8'h01);
      add(1'b0, 8'hCD, 8'h01, 1, 8'hCD, 8'h00, 8'h00, 8'h00);
      // reset during a pending change, then full latency from release
      add(1'b0, 8'hF0, 8'h00, 2, 8'hCD, 8'h00, 8'h00, 8'h00);
      add(1'b1, 8'hF0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hF0, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1'b0, 8'hF0, 8'h00, 1, 8'hF0, 8'hF0, 8'h00, 8'hF0);
      add(1'b0, 8'hF0, 8'h00, 1, 8'hF0, 8'h00, 8'h00, 8'hF0);

      foreach (vt[k]) begin
         rst      = vt[k].rst;
         bus.iDIn = vt[k].din;
         bus.iClr = vt[k].clr;
         repeat (vt[k].n) @(posedge clk);
         #2;
         check($sformatf("vec%0d.dout", k), bus.oDOut, vt[k].dout);
         check($sformatf("vec%0d.rise", k), bus.oRise, vt[k].rise);
         check($sformatf("vec%0d.fall", k), bus.oFall, vt[k].fall);
         check($sformatf("vec%0d.evt",  k), bus.oEvt,  vt[k].evt);
      end

      // Randomised run against the model, starting from a common reset.
      din_r = '0;
      for (int c = 0; c < 4000; c++) begin
         rst_r = (c == 0) || ($urandom_range(0, 299) == 0);
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, 3) == 0) din_r[b] = ~din_r[b];
            clr_r[b] = ($urandom_range(0, 7) == 0);
         end
         rst      = rst_r;
         bus.iDIn = din_r;
         bus.iClr = clr_r;
         model_step(rst_r, din_r, clr_r);
         @(posedge clk);
         #2;
         check("rnd.dout", bus.oDOut, m_out);
         check("rnd.rise", bus.oRise, m_rise);
         check("rnd.fall", bus.oFall, m_fall);
         check("rnd.evt",  bus.oEvt,  m_evt);
         if ((bus.oRise & bus.oFall) != '0) begin
            n_chk++;
            n_err++;
            $display("FAIL rnd.excl: rise %02h and fall %02h overlap", bus.oRise, bus.oFall);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
